// File: rtl/mpu_alu_arb.sv
//------------------------------------------------------------------------------
// mpu_alu_arb
//
// Shares one combinational mpu_alu among NREQ requesters (decode/execute units).
// One operation is in flight at a time:
//   IDLE : pick a winner round-robin, accept it, register its operands into alu_*
//   EXEC : one cycle for the ALU to settle, capture alu_res/alu_flags
//   RESP : present rsp_valid to the winner until it asserts its rsp_ready bit
//
// Optional feature macro: MPU_ALU_ARB_PRIO_EN
//   defined   : requester 0 has strict priority; 1..NREQ-1 are round-robin among
//               themselves and only their grants move the pointer
//   undefined : pure round-robin over all NREQ requesters
//
// Ports (requester i occupies slice i of every packed per-requester bus):
//   sys_clk, sys_rst          clock, synchronous active-high reset
//   req_valid / req_ready     request handshake (req_ready one-hot, IDLE only)
//   req_size/op/o0..o2/s0..s2 operation fields per requester
//   rsp_valid / rsp_ready     response handshake (rsp_valid one-hot)
//   rsp_res, rsp_flags        captured ALU result, shared by all requesters
//   alu_*                     registered operands to the ALU
//   alu_res, alu_flags        ALU result inputs
//   busy                      high whenever an operation is in flight
//------------------------------------------------------------------------------
module mpu_alu_arb #(
   parameter int NREQ = 4
) (
   input  logic                sys_clk,
   input  logic                sys_rst,
   input  logic [NREQ-1:0]     req_valid,
   output logic [NREQ-1:0]     req_ready,
   input  logic [2*NREQ-1:0]   req_size,
   input  logic [4*NREQ-1:0]   req_op,
   input  logic [64*NREQ-1:0]  req_o0,
   input  logic [64*NREQ-1:0]  req_o1,
   input  logic [64*NREQ-1:0]  req_o2,
   input  logic [3*NREQ-1:0]   req_s0,
   input  logic [3*NREQ-1:0]   req_s1,
   input  logic [3*NREQ-1:0]   req_s2,
   output logic [NREQ-1:0]     rsp_valid,
   input  logic [NREQ-1:0]     rsp_ready,
   output logic [63:0]         rsp_res,
   output logic [7:0]          rsp_flags,
   output logic [1:0]          alu_size,
   output logic [3:0]          alu_op,
   output logic [63:0]         alu_o0,
   output logic [63:0]         alu_o1,
   output logic [63:0]         alu_o2,
   output logic [2:0]          alu_s0,
   output logic [2:0]          alu_s1,
   output logic [2:0]          alu_s2,
   input  logic [63:0]         alu_res,
   input  logic [7:0]          alu_flags,
   output logic                busy
);

   localparam int IW = $clog2(NREQ);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   state_t          state_r;
   logic [IW-1:0]   ptr_r;
   logic [IW-1:0]   gnt_id_r;

   logic [IW-1:0]   winner_s;
   logic            found_s;
   logic [IW-1:0]   idx_s;
   logic            hit_s;
   int              idx_v;

   // Winner search starting one past the last grant, wrapping around
   always_comb begin
      winner_s = '0;
      found_s  = 1'b0;
      idx_v    = 0;
      idx_s    = '0;
      hit_s    = 1'b0;
`ifdef MPU_ALU_ARB_PRIO_EN
      // Requester 0 pre-empts; ptr only ever holds 1..NREQ-1 here
      found_s = req_valid[0];
      for (int k = 1; k < NREQ; k++) begin
         idx_v    = ((int'(ptr_r) - 1 + k) % (NREQ - 1)) + 1;
         idx_s    = IW'(idx_v);
         hit_s    = !found_s && req_valid[idx_s];
         winner_s = hit_s ? idx_s : winner_s;
         found_s  = found_s | hit_s;
      end
`else
      for (int k = 1; k <= NREQ; k++) begin
         idx_v    = (int'(ptr_r) + k) % NREQ;
         idx_s    = IW'(idx_v);
         hit_s    = !found_s && req_valid[idx_s];
         winner_s = hit_s ? idx_s : winner_s;
         found_s  = found_s | hit_s;
      end
`endif
   end

   // Handshake decode: accept only in IDLE and never while reset is applied
   always_comb begin
      req_ready = '0;
      rsp_valid = '0;
      if (state_r == ST_IDLE && found_s && !sys_rst) begin
         req_ready[winner_s] = 1'b1;
      end else begin
         req_ready = '0;
      end
      if (state_r == ST_RESP) begin
         rsp_valid[gnt_id_r] = 1'b1;
      end else begin
         rsp_valid = '0;
      end
   end

   assign busy = (state_r != ST_IDLE);

   // Sequencer FSM with registered ALU operands and captured result
   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         state_r   <= ST_IDLE;
         ptr_r     <= IW'(NREQ - 1);
         gnt_id_r  <= '0;
         alu_size  <= 2'd0;
         alu_op    <= 4'd0;
         alu_o0    <= 64'd0;
         alu_o1    <= 64'd0;
         alu_o2    <= 64'd0;
         alu_s0    <= 3'd0;
         alu_s1    <= 3'd0;
         alu_s2    <= 3'd0;
         rsp_res   <= 64'd0;
         rsp_flags <= 8'd0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (found_s) begin
                  alu_size <= req_size[int'(winner_s)*2 +: 2];
                  alu_op   <= req_op[int'(winner_s)*4 +: 4];
                  alu_o0   <= req_o0[int'(winner_s)*64 +: 64];
                  alu_o1   <= req_o1[int'(winner_s)*64 +: 64];
                  alu_o2   <= req_o2[int'(winner_s)*64 +: 64];
                  alu_s0   <= req_s0[int'(winner_s)*3 +: 3];
                  alu_s1   <= req_s1[int'(winner_s)*3 +: 3];
                  alu_s2   <= req_s2[int'(winner_s)*3 +: 3];
                  gnt_id_r <= winner_s;
`ifdef MPU_ALU_ARB_PRIO_EN
                  // Priority grants to requester 0 leave the rotation untouched
                  if (winner_s != '0) begin
                     ptr_r <= winner_s;
                  end else begin
                     ptr_r <= ptr_r;
                  end
`else
                  ptr_r    <= winner_s;
`endif
                  state_r  <= ST_EXEC;
               end else begin
                  state_r  <= ST_IDLE;
               end
            end
            ST_EXEC: begin
               // ALU inputs have been stable for a full cycle
               rsp_res   <= alu_res;
               rsp_flags <= alu_flags;
               state_r   <= ST_RESP;
            end
            ST_RESP: begin
               if (rsp_ready[gnt_id_r]) begin
                  state_r <= ST_IDLE;
               end else begin
                  state_r <= ST_RESP;
               end
            end
            default: begin
               state_r <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mpu_alu_arb.sv
//------------------------------------------------------------------------------
// Bench for mpu_alu_arb: a stub ALU drives alu_res/alu_flags from the DUT's
// alu_* outputs; a transaction-level model tracks what each output must be and
// is compared every cycle, while directed sequences pin literal expectations.
//------------------------------------------------------------------------------
module tb_mpu_alu_arb;

   localparam int N = 4;

   logic             sys_clk = 1'b0;
   logic             sys_rst;
   logic [N-1:0]     req_valid;
   logic [N-1:0]     req_ready;
   logic [2*N-1:0]   req_size;
   logic [4*N-1:0]   req_op;
   logic [64*N-1:0]  req_o0, req_o1, req_o2;
   logic [3*N-1:0]   req_s0, req_s1, req_s2;
   logic [N-1:0]     rsp_valid;
   logic [N-1:0]     rsp_ready;
   logic [63:0]      rsp_res;
   logic [7:0]       rsp_flags;
   logic [1:0]       alu_size;
   logic [3:0]       alu_op;
   logic [63:0]      alu_o0, alu_o1, alu_o2;
   logic [2:0]       alu_s0, alu_s1, alu_s2;
   logic [63:0]      alu_res;
   logic [7:0]       alu_flags;
   logic             busy;

   int checks = 0;
   int errors = 0;
   bit chk_en = 1'b0;

   mpu_alu_arb #(.NREQ(N)) dut (
      .sys_clk(sys_clk), .sys_rst(sys_rst),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_size(req_size), .req_op(req_op),
      .req_o0(req_o0), .req_o1(req_o1), .req_o2(req_o2),
      .req_s0(req_s0), .req_s1(req_s1), .req_s2(req_s2),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_res(rsp_res), .rsp_flags(rsp_flags),
      .alu_size(alu_size), .alu_op(alu_op),
      .alu_o0(alu_o0), .alu_o1(alu_o1), .alu_o2(alu_o2),
      .alu_s0(alu_s0), .alu_s1(alu_s1), .alu_s2(alu_s2),
      .alu_res(alu_res), .alu_flags(alu_flags),
      .busy(busy)
   );

   always #5 sys_clk = ~sys_clk;

   // Stub ALU: op1 masked sum, op2 three-way equal, op3 byte less-than,
   // op4 byte extract of o2, anything else (incl. op 0) yields 0
   function automatic logic [63:0] alu_fn(input logic [1:0] sz, input logic [3:0] op,
                                          input logic [63:0] a, input logic [63:0] b,
                                          input logic [63:0] c, input logic [2:0] sa,
                                          input logic [2:0] sb, input logic [2:0] sc);
      logic [63:0] mask;
      logic [63:0] r;
      case (sz)
         2'd0:    mask = 64'hFF;
         2'd1:    mask = 64'hFFFF;
         2'd2:    mask = 64'hFFFF_FFFF;
         default: mask = 64'hFFFF_FFFF_FFFF_FFFF;
      endcase
      case (op)
         4'd1:    r = (a + b + c) & mask;
         4'd2:    r = (a == b && b == c) ? 64'd1 : 64'd0;
         4'd3:    r = (((a >> {sa, 3'b000}) & 64'hFF) < ((b >> {sb, 3'b000}) & 64'hFF)) ? 64'd1 : 64'd0;
         4'd4:    r = (c >> {sc, 3'b000}) & 64'hFF;
         default: r = 64'd0;
      endcase
      return r;
   endfunction

   function automatic logic [7:0] flg_fn(input logic [3:0] op, input logic [1:0] sz,
                                         input logic [63:0] r);
      return {op, sz, (r == 64'd0), ^r};
   endfunction

   logic [63:0] stub_res;
   always_comb begin
      stub_res  = alu_fn(alu_size, alu_op, alu_o0, alu_o1, alu_o2, alu_s0, alu_s1, alu_s2);
      alu_res   = stub_res;
      alu_flags = flg_fn(alu_op, alu_size, stub_res);
   end

   // Arbitration rule: first valid requester after the last grant, with wrap
   function automatic int pick_winner(input logic [N-1:0] v, input int ptr);
`ifdef MPU_ALU_ARB_PRIO_EN
      if (v[0]) return 0;
      for (int k = 1; k < N; k++) begin
         if (v[((ptr - 1 + k) % (N - 1)) + 1]) return ((ptr - 1 + k) % (N - 1)) + 1;
      end
`else
      for (int k = 1; k <= N; k++) begin
         if (v[(ptr + k) % N]) return (ptr + k) % N;
      end
`endif
      return -1;
   endfunction

   // Transaction model: age 0 = nothing in flight, 1 = just accepted, 2 = answering
   int          m_age = 0;
   int          m_ptr = N - 1;
   int          m_gnt = 0;
   logic [63:0] m_res = 64'd0;
   logic [7:0]  m_flags = 8'd0;
   logic [1:0]  m_size = 2'd0;
   logic [3:0]  m_op = 4'd0;
   logic [63:0] m_o0 = 64'd0, m_o1 = 64'd0, m_o2 = 64'd0;
   logic [2:0]  m_s0 = 3'd0, m_s1 = 3'd0, m_s2 = 3'd0;
   int          cyc = 0;
   int          grant_log[$];
   int          accept_cyc[$];

   always @(posedge sys_clk) begin : model
      int w;
      logic [63:0] r;
      cyc <= cyc + 1;
      w = pick_winner(req_valid, m_ptr);
      r = alu_fn(m_size, m_op, m_o0, m_o1, m_o2, m_s0, m_s1, m_s2);
      if (sys_rst) begin
         m_age <= 0; m_ptr <= N - 1; m_gnt <= 0; m_res <= 64'd0; m_flags <= 8'd0;
         m_size <= 2'd0; m_op <= 4'd0; m_o0 <= 64'd0; m_o1 <= 64'd0; m_o2 <= 64'd0;
         m_s0 <= 3'd0; m_s1 <= 3'd0; m_s2 <= 3'd0;
      end else if (m_age == 0) begin
         if (w >= 0) begin
            m_size <= req_size[w*2 +: 2];   m_op <= req_op[w*4 +: 4];
            m_o0 <= req_o0[w*64 +: 64];     m_o1 <= req_o1[w*64 +: 64];
            m_o2 <= req_o2[w*64 +: 64];     m_s0 <= req_s0[w*3 +: 3];
            m_s1 <= req_s1[w*3 +: 3];       m_s2 <= req_s2[w*3 +: 3];
            m_gnt <= w;
`ifdef MPU_ALU_ARB_PRIO_EN
            if (w != 0) m_ptr <= w;
`else
            m_ptr <= w;
`endif
            grant_log.push_back(w);
            accept_cyc.push_back(cyc);
            m_age <= 1;
         end
      end else if (m_age == 1) begin
         m_res   <= r;
         m_flags <= flg_fn(m_op, m_size, r);
         m_age   <= 2;
      end else begin
         if (rsp_ready[m_gnt]) m_age <= 0;
      end
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Every-cycle comparison of DUT outputs against the model
   always @(negedge sys_clk) begin : compare
      int w;
      logic [N-1:0] exp_rdy;
      if (chk_en) begin
         w = pick_winner(req_valid, m_ptr);
         exp_rdy = (!sys_rst && m_age == 0 && w >= 0) ? (4'b0001 << w) : 4'b0000;
         chk("req_ready", 64'(req_ready), 64'(exp_rdy));
         chk("rsp_valid", 64'(rsp_valid), (m_age == 2) ? 64'(4'b0001 << m_gnt) : 64'd0);
         chk("busy", 64'(busy), (m_age != 0) ? 64'd1 : 64'd0);
         chk("rsp_res", rsp_res, m_res);
         chk("rsp_flags", 64'(rsp_flags), 64'(m_flags));
         chk("alu_op", 64'(alu_op), 64'(m_op));
         chk("alu_size", 64'(alu_size), 64'(m_size));
         chk("alu_o0", alu_o0, m_o0);
         chk("alu_o1", alu_o1, m_o1);
         chk("alu_o2", alu_o2, m_o2);
         chk("alu_sel", 64'({alu_s0, alu_s1, alu_s2}), 64'({m_s0, m_s1, m_s2}));
      end
   end

   task automatic step();
      @(posedge sys_clk);
      #1;
   endtask

   task automatic mid();
      @(negedge sys_clk);
   endtask

   task automatic do_reset();
      sys_rst = 1'b1;
      step();
      sys_rst = 1'b0;
   endtask

   task automatic set_req(input int i, input logic [1:0] sz, input logic [3:0] op,
                          input logic [63:0] a, input logic [63:0] b, input logic [63:0] c,
                          input logic [2:0] sa, input logic [2:0] sb, input logic [2:0] sc);
      req_size[i*2 +: 2] = sz;  req_op[i*4 +: 4] = op;
      req_o0[i*64 +: 64] = a;   req_o1[i*64 +: 64] = b;   req_o2[i*64 +: 64] = c;
      req_s0[i*3 +: 3] = sa;    req_s1[i*3 +: 3] = sb;    req_s2[i*3 +: 3] = sc;
   endtask

   initial begin
      #20000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      sys_rst = 1'b1; req_valid = '0; rsp_ready = '0;
      req_size = '0; req_op = '0; req_o0 = '0; req_o1 = '0; req_o2 = '0;
      req_s0 = '0; req_s1 = '0; req_s2 = '0;
      step(); step();
      chk_en = 1'b1;
      mid();
      chk("lit_rst_busy", 64'(busy), 64'd0);
      chk("lit_rst_alu_op", 64'(alu_op), 64'd0);
      chk("lit_rst_rsp_res", rsp_res, 64'd0);

      // Single op: byte 1 of 0x500 (=5) < 7 -> 1, busy for exactly 2 cycles
      step();
      sys_rst = 1'b0; rsp_ready = 4'hF;
      set_req(0, 2'd0, 4'd3, 64'h500, 64'h7, 64'h0, 3'd1, 3'd0, 3'd0);
      req_valid = 4'b0001;
      mid();
      chk("lit_t1_ready", 64'(req_ready), 64'(4'b0001));
      step(); req_valid = 4'b0000;
      mid();
      chk("lit_t1_exec_busy", 64'(busy), 64'd1);
      chk("lit_t1_exec_valid", 64'(rsp_valid), 64'd0);
      step(); mid();
      chk("lit_t1_resp_valid", 64'(rsp_valid), 64'(4'b0001));
      chk("lit_t1_res", rsp_res, 64'd1);
      step(); mid();
      chk("lit_t1_done_busy", 64'(busy), 64'd0);

`ifndef MPU_ALU_ARB_PRIO_EN
      // Round-robin over all four, one accept every 3 cycles
      do_reset();
      grant_log.delete(); accept_cyc.delete();
      for (int i = 0; i < N; i++) begin
         set_req(i, 2'(i), (i == 3) ? 4'hF : 4'd1, 64'(100 + i), 64'(7 * i), 64'd3,
                 3'(i), 3'd0, 3'd2);
      end
      req_valid = 4'hF; rsp_ready = 4'hF;
      repeat (13) step();
      req_valid = 4'h0;
      repeat (3) step();
      chk("lit_rr_count", 64'(grant_log.size()), 64'd5);
      if (grant_log.size() == 5) begin
         chk("lit_rr_order0", 64'(grant_log[0]), 64'd0);
         chk("lit_rr_order1", 64'(grant_log[1]), 64'd1);
         chk("lit_rr_order2", 64'(grant_log[2]), 64'd2);
         chk("lit_rr_order3", 64'(grant_log[3]), 64'd3);
         chk("lit_rr_order4", 64'(grant_log[4]), 64'd0);
         for (int k = 1; k < 5; k++) begin
            chk("lit_rr_spacing", 64'(accept_cyc[k] - accept_cyc[k-1]), 64'd3);
         end
      end
`endif

      // Backpressure: result held while requester 1 withholds rsp_ready
      do_reset();
      set_req(1, 2'd3, 4'd2, 64'hFF00, 64'hFF00, 64'hFF00, 3'd0, 3'd0, 3'd0);
      req_valid = 4'b0010; rsp_ready = 4'b1101;
      step(); req_valid = 4'b0101;
      step();
      for (int k = 0; k < 5; k++) begin
         mid();
         chk("lit_bp_valid", 64'(rsp_valid), 64'(4'b0010));
         chk("lit_bp_res", rsp_res, 64'd1);
         chk("lit_bp_no_ready", 64'(req_ready), 64'd0);
         step();
      end
      rsp_ready = 4'hF;
      step(); mid();
      chk("lit_bp_next_grant", 64'(req_ready), 64'(4'b0100));
      step(); req_valid = 4'b0000;
      step(); step(); mid();
      chk("lit_bp_idle", 64'(busy), 64'd0);

      // Operands may change after acceptance
      do_reset();
      set_req(1, 2'd0, 4'd3, 64'd2, 64'd9, 64'd0, 3'd0, 3'd0, 3'd0);
      req_valid = 4'b0010; rsp_ready = 4'hF;
      step();
      req_o0[64 +: 64] = 64'hFFFF; req_valid = 4'b0000;
      step(); mid();
      chk("lit_oc_res", rsp_res, 64'd1);
      chk("lit_oc_alu_o0", alu_o0, 64'd2);
      step();

      // Reset while answering requester 2
      set_req(2, 2'd1, 4'd1, 64'h1234, 64'h1, 64'h0, 3'd0, 3'd0, 3'd0);
      req_valid = 4'b0100; rsp_ready = 4'h0;
      step(); req_valid = 4'b0000;
      step();
      sys_rst = 1'b1;
      mid();
      chk("lit_rr_resp_valid", 64'(rsp_valid), 64'(4'b0100));
      step();
      sys_rst = 1'b0; req_valid = 4'b0101;
      mid();
      chk("lit_rst_mid_valid", 64'(rsp_valid), 64'd0);
      chk("lit_rst_mid_busy", 64'(busy), 64'd0);
      chk("lit_rst_mid_alu_op", 64'(alu_op), 64'd0);
      chk("lit_rst_mid_grant", 64'(req_ready), 64'(4'b0001));
      step(); req_valid = 4'b0000; rsp_ready = 4'hF;
      repeat (3) step();

`ifdef MPU_ALU_ARB_PRIO_EN
      // Strict priority for requester 0, then round-robin among 1..3
      do_reset();
      grant_log.delete();
      req_valid = 4'hF; rsp_ready = 4'hF;
      repeat (10) step();
      req_valid = 4'h0;
      repeat (3) step();
      chk("lit_pr_count", 64'(grant_log.size()), 64'd4);
      foreach (grant_log[k]) chk("lit_pr_zero", 64'(grant_log[k]), 64'd0);
      grant_log.delete();
      req_valid = 4'b1110;
      repeat (10) step();
      req_valid = 4'h0;
      repeat (3) step();
      chk("lit_pr_rr_count", 64'(grant_log.size()), 64'd4);
      if (grant_log.size() == 4) begin
         chk("lit_pr_order0", 64'(grant_log[0]), 64'd1);
         chk("lit_pr_order1", 64'(grant_log[1]), 64'd2);
         chk("lit_pr_order2", 64'(grant_log[2]), 64'd3);
         chk("lit_pr_order3", 64'(grant_log[3]), 64'd1);
      end
`endif

      step();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/mpu_alu_arb.md
Name: mpu_alu_arb

Overview:
- Round-robin arbiter and sequencer that shares one mpu_alu instance among NREQ requesters inside the MPU.
- Accepts one operation at a time and drives registered operands into the ALU.
- Captures the ALU result and returns it to the winning requester with a valid/ready handshake.
- Sits between the MPU decode/execute units (requesters) and the combinational ALU.

Parameters:
NREQ, 4, number of requesters (2..8); all per-requester buses are packed, requester i in slice i.

Ports:
sys_clk  in  1  system clock
sys_rst  in  1  synchronous reset, active-high
req_valid  in  NREQ  request pending per requester
req_ready  out  NREQ  one-hot accept, combinational, IDLE only
req_size  in  2*NREQ  operation size per requester
req_op  in  4*NREQ  ALU op code per requester
req_o0, req_o1, req_o2  in  64*NREQ each  operands
req_s0, req_s1, req_s2  in  3*NREQ each  selectors
rsp_valid  out  NREQ  one-hot result valid
rsp_ready  in  NREQ  result consumed per requester
rsp_res  out  64  result, shared by all requesters
rsp_flags  out  8  flags, shared
alu_size  out  2  registered, to ALU
alu_op  out  4  registered, to ALU
alu_o0, alu_o1, alu_o2  out  64 each  registered, to ALU
alu_s0, alu_s1, alu_s2  out  3 each  registered, to ALU
alu_res  in  64  from ALU, combinational
alu_flags  in  8  from ALU
busy  out  1  high whenever state != IDLE

Behaviour:
- Clock and reset: one clock, sys_clk; sys_rst is synchronous and active-high.
- Reset values:
  - state = IDLE.
  - ptr (last granted) = NREQ-1, so requester 0 wins first.
  - All alu_* outputs = 0; op 0 makes the ALU return 0.
  - rsp_res = 0, rsp_flags = 0.
  - rsp_valid = 0, req_ready = 0, busy = 0.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - Winner = first i with req_valid[i], searching (ptr+1) mod NREQ upward with wrap-around.
  - req_ready[winner] = 1 in the same cycle; all other bits 0.
  - No req_valid: stay IDLE, req_ready = 0.
  - On accept, in the same cycle:
    - Register the winner's size/op/operands/selectors into alu_*.
    - gnt_id <= winner, ptr <= winner.
    - Next state = EXEC.
- EXEC (exactly 1 cycle): rsp_res <= alu_res, rsp_flags <= alu_flags; next state = RESP.
- RESP:
  - rsp_valid[gnt_id] = 1; all other bits 0.
  - When rsp_ready[gnt_id] = 1: next state = IDLE.
  - rsp_ready on non-granted bits is ignored.
  - rsp_res and rsp_flags hold stable until the next EXEC.
- Latency and throughput:
  - Result visible 2 cycles after the accept edge.
  - Minimum 3 cycles per operation when the response is consumed immediately.
  - A new grant is never made in the same cycle as response completion.
- alu_* outputs hold their last values outside the accept cycle.
- Operand stability:
  - Requester inputs may change freely after acceptance.
  - A requester may drop req_valid before acceptance; no side effect.
- Fairness: a continuously requesting requester is granted within NREQ operations.
- Reset mid-operation (EXEC or RESP):
  - Operation is abandoned; no rsp_valid is issued.
  - All outputs return to reset values on the next edge.
- Unknown op codes are passed through unchanged; the ALU yields 0.

Optional Feature:
- Macro: MPU_ALU_ARB_PRIO_EN.
- Defined:
  - Requester 0 has strict priority and wins whenever req_valid[0] = 1 in IDLE.
  - Requesters 1..NREQ-1 are round-robin among themselves.
  - ptr updates only on grants to requesters 1..NREQ-1; reset ptr = NREQ-1.
- Not defined: pure round-robin over all NREQ requesters, as described above.

Test Plan:
- Single op: after reset, req_valid = 0001 with op 3, size 0, o0 = 0x500, s0 = 1 (byte 5), o1 = 0x07, s1 = 0 -> req_ready = 0001 in the same cycle, rsp_valid = 0001 two cycles later, rsp_res = 1, busy high for exactly 2 cycles with rsp_ready tied high.
- Round-robin: req_valid = 1111 held, rsp_ready = 1111 -> grant order 0,1,2,3,0; one accept every 3 cycles.
- Backpressure: op 2, o0 = o1 = 0xFF00, o2 = 0xFF00, size 3; rsp_ready held low for 5 cycles -> rsp_valid stays high and rsp_res stays 1 throughout; no new req_ready while in RESP.
- Operand change after accept: req1 op 3 with o0 = 2, o1 = 9 accepted; o0 changed to 0xFFFF the next cycle -> rsp_res = 1.
- Reset in RESP: sys_rst pulsed while rsp_valid = 0100 -> next cycle rsp_valid = 0, busy = 0, alu_op = 0; following grant goes to requester 0 if valid.
- MPU_ALU_ARB_PRIO_EN defined: req_valid = 1111 continuously -> requester 0 granted every operation.
- MPU_ALU_ARB_PRIO_EN defined, req_valid = 1110 -> order 1,2,3,1.
